// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the TMR decoder controller.
package cv32e40p_pkg;

  // One lane result packed as {illegal, is_compressed, instr[31:0]}
  localparam int unsigned TMR_BUNDLE_W = 34;

  typedef enum logic [1:0] {
    TMR_FULL     = 2'b00,
    TMR_DEGRADED = 2'b01,
    TMR_FAIL     = 2'b10
  } tmr_state_e;

endpackage

// File: rtl/cv32e40p_tmr_voter3.sv
// Bitwise 2-of-3 majority over three lane bundles, plus per-lane disagreement flags.
module cv32e40p_tmr_voter3
  import cv32e40p_pkg::*;
(
  input  logic [TMR_BUNDLE_W-1:0] lane_1,
  input  logic [TMR_BUNDLE_W-1:0] lane_2,
  input  logic [TMR_BUNDLE_W-1:0] lane_3,
  output logic [TMR_BUNDLE_W-1:0] maj,
  output logic [2:0]              mis
);

  // Majority per bit, then flag every lane that disagrees with it
  always_comb begin
    maj    = (lane_1 & lane_2) | (lane_1 & lane_3) | (lane_2 & lane_3);
    mis[0] = (lane_1 != maj);
    mis[1] = (lane_2 != maj);
    mis[2] = (lane_3 != maj);
  end

endmodule

// File: rtl/cv32e40p_tmr_decoder_ctrl.sv
// Triple-redundant decoder result voter with fault tracking and a one-deep output register.
module cv32e40p_tmr_decoder_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned FAULT_THRESH = 4,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_1_i,
  input  logic [31:0]          instr_2_i,
  input  logic [31:0]          instr_3_i,
  input  logic                 is_compressed_1_i,
  input  logic                 is_compressed_2_i,
  input  logic                 is_compressed_3_i,
  input  logic                 illegal_instr_1_i,
  input  logic                 illegal_instr_2_i,
  input  logic                 illegal_instr_3_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          instr_o,
  output logic                 is_compressed_o,
  output logic                 illegal_instr_o,
  input  logic                 clear_i,
  output logic                 fault_o,
  output logic [2:0]           lane_dis_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] mismatch_cnt_o
);

  localparam logic [3:0] THRESH = 4'(FAULT_THRESH);

  logic [TMR_BUNDLE_W-1:0] bundle_1, bundle_2, bundle_3, maj, vote;
  logic [2:0]              maj_mis, mis, mis_en, cnt_hit, new_dis;
  logic [2:0][3:0]         lane_cnt_q, lane_cnt_d;
  logic [2:0]              lane_dis_q;
  logic [CNT_WIDTH-1:0]    mcnt_q;
  tmr_state_e              state_q, state_d;
  logic                    accept, dis_two, force_illegal;

  assign bundle_1 = {illegal_instr_1_i, is_compressed_1_i, instr_1_i};
  assign bundle_2 = {illegal_instr_2_i, is_compressed_2_i, instr_2_i};
  assign bundle_3 = {illegal_instr_3_i, is_compressed_3_i, instr_3_i};

  cv32e40p_tmr_voter3 u_voter (
    .lane_1 (bundle_1),
    .lane_2 (bundle_2),
    .lane_3 (bundle_3),
    .maj    (maj),
    .mis    (maj_mis)
  );

  assign in_ready_o     = !out_valid_o || out_ready_i;
  assign accept         = in_valid_i && in_ready_o;
  assign lane_dis_o     = lane_dis_q;
  assign mismatch_cnt_o = mcnt_q;
  assign state_o        = state_q;
  assign fault_o        = (state_q == TMR_FAIL);

  // Vote source: majority with all lanes alive, otherwise the lowest-indexed enabled lane
  always_comb begin
    vote = maj;
    mis  = maj_mis;
    if (state_q != TMR_FULL) begin
      if (!lane_dis_q[0])      vote = bundle_1;
      else if (!lane_dis_q[1]) vote = bundle_2;
      else if (!lane_dis_q[2]) vote = bundle_3;
      else                     vote = bundle_1;
      mis = {bundle_3 != vote, bundle_2 != vote, bundle_1 != vote};
    end
  end

  // Per-lane consecutive-mismatch counters and the disable conditions they produce
  always_comb begin
    mis_en = mis & ~lane_dis_q;
    for (int i = 0; i < 3; i++) begin
      lane_cnt_d[i] = lane_cnt_q[i];
      if (mis_en[i]) begin
        if (lane_cnt_q[i] != THRESH) lane_cnt_d[i] = lane_cnt_q[i] + 4'd1;
      end else if (!mis[i]) begin
        lane_cnt_d[i] = 4'd0;
      end
      cnt_hit[i] = (lane_cnt_d[i] == THRESH);
    end
    new_dis = cnt_hit & ~lane_dis_q;
    dis_two = (new_dis[0] & new_dis[1]) | (new_dis[0] & new_dis[2]) | (new_dis[1] & new_dis[2]);
  end

  // Next redundancy state for an accepted transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      TMR_FULL: begin
        if ((&mis) || dis_two) state_d = TMR_FAIL;
        else if (|new_dis)     state_d = TMR_DEGRADED;
      end
      TMR_DEGRADED: begin
        if (|mis_en) state_d = TMR_FAIL;
      end
      default: state_d = TMR_FAIL;
    endcase
    // A clear on the same cycle cancels this transfer's comparison, so only an existing FAIL forces illegal
    force_illegal = (state_q == TMR_FAIL) || (!clear_i && (state_d == TMR_FAIL));
  end

  // Fault-tracking state: clear wins over an accepted comparison
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TMR_FULL;
      lane_cnt_q <= '0;
      lane_dis_q <= '0;
      mcnt_q     <= '0;
    end else if (clear_i) begin
      state_q    <= TMR_FULL;
      lane_cnt_q <= '0;
      lane_dis_q <= '0;
      mcnt_q     <= '0;
    end else if (accept) begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      lane_dis_q <= lane_dis_q | cnt_hit;
      if ((|mis_en) && (mcnt_q != {CNT_WIDTH{1'b1}})) mcnt_q <= mcnt_q + CNT_WIDTH'(1);
    end
  end

  // Output register: load on acceptance, hold while stalled, drain when consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o     <= 1'b0;
      instr_o         <= '0;
      is_compressed_o <= 1'b0;
      illegal_instr_o <= 1'b0;
    end else if (accept) begin
      out_valid_o     <= 1'b1;
      instr_o         <= vote[31:0];
      is_compressed_o <= vote[32];
      illegal_instr_o <= vote[33] | force_illegal;
    end else if (out_ready_i) begin
      out_valid_o     <= 1'b0;
    end
  end

endmodule

// File: doc/cv32e40p_tmr_decoder_ctrl.md
CV32E40P_TMR_DECODER_CTRL -- requirements
Module: cv32e40p_tmr_decoder_ctrl

Interface
REQ-001 SHALL have parameter FAULT_THRESH, default 4, consecutive per-lane mismatches before the lane is disabled (range 1..15).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the total-mismatch event counter.
REQ-003 SHALL have port clk, input, 1 bit, single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): upstream handshake for the three decoder results.
REQ-006 SHALL have ports instr_1_i, instr_2_i, instr_3_i, input, 32 bits each: decompressed instruction from lanes 1..3.
REQ-007 SHALL have ports is_compressed_1_i..3_i and illegal_instr_1_i..3_i, input, 1 bit each: per-lane flags.
REQ-008 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1): downstream handshake.
REQ-009 SHALL have ports instr_o (output, 32), is_compressed_o (output, 1) and illegal_instr_o (output, 1): registered voted result.
REQ-010 SHALL have ports clear_i (input, 1), fault_o (output, 1), lane_dis_o (output, 3, bit i = lane i+1 disabled), state_o (output, 2) and mismatch_cnt_o (output, CNT_WIDTH).

Function
REQ-011 SHALL treat each lane as a 34-bit bundle {illegal, is_compressed, instr}.
REQ-012 SHALL compute the vote as the bitwise majority of the three bundles in TMR_FULL.
REQ-013 SHALL take the vote from the lowest-indexed enabled lane in TMR_DEGRADED and TMR_FAIL.
REQ-014 SHALL flag a lane as mismatching when its bundle differs from the vote.
REQ-015 SHALL accept a transfer when in_valid_i and in_ready_o are both high.
REQ-016 SHALL drive in_ready_o = !out_valid_o || out_ready_i.
REQ-017 SHALL register the voted bundle on acceptance, giving 1-cycle latency.
REQ-018 SHALL hold output data stable while out_valid_o=1 and out_ready_i=0.
REQ-019 SHALL update per-lane counters only on acceptance: an enabled mismatching lane increments (saturating at FAULT_THRESH); a matching lane clears to 0.
REQ-020 SHALL set a lane's lane_dis_o bit sticky when its counter reaches FAULT_THRESH.
REQ-021 SHALL increment mismatch_cnt_o by 1 (saturating at all-ones) on each accepted transfer with any enabled-lane mismatch.
REQ-022 SHALL implement these state transitions:
- TMR_FULL -> TMR_DEGRADED when exactly one lane becomes disabled.
- TMR_FULL -> TMR_FAIL when two or more lanes are disabled in the same cycle, or all three lanes mismatch the vote.
- TMR_DEGRADED -> TMR_FAIL on any mismatch between the two enabled lanes.
- TMR_FAIL: terminal until clear_i.
REQ-023 SHALL force illegal_instr_o=1 for the transfer that causes entry to TMR_FAIL and for every transfer while in TMR_FAIL.
REQ-024 SHALL drive fault_o=1 exactly while in TMR_FAIL.
REQ-025 SHALL, on clear_i=1, in the next cycle: go to TMR_FULL, clear lane counters, lane_dis_o and mismatch_cnt_o; out_valid_o and the output data are unaffected.
REQ-026 SHALL, when clear_i coincides with an acceptance, give clear priority: that transfer's data passes using the pre-clear vote, and its comparison is not counted.
REQ-027 SHALL encode state_o as TMR_FULL=2'b00, TMR_DEGRADED=2'b01, TMR_FAIL=2'b10.

Reset
REQ-028 SHALL, on rst_n low and asynchronously, set out_valid_o=0, instr_o=0, is_compressed_o=0, illegal_instr_o=0, state TMR_FULL, all counters 0, lane_dis_o=0 and fault_o=0.
REQ-029 SHALL, for reset asserted mid-transfer, drop the pending output with no handshake completion.

Structure
REQ-030 SHALL place the state typedef tmr_state_e and the 34-bit bundle width constant in cv32e40p_pkg.
REQ-031 SHALL instantiate one combinational sub-module, cv32e40p_tmr_voter3, which computes the bitwise majority and the three per-lane mismatch bits.

Verification
REQ-032 SHALL test: three identical lanes 0x00000013, 10 transfers -> outputs match, mismatch_cnt_o=0, state_o=00.
REQ-033 SHALL test: lane 2 instr bit 0 flipped for 4 consecutive transfers -> instr_o correct throughout, lane_dis_o=3'b010 and state_o=01 after the 4th acceptance.
REQ-034 SHALL test: in TMR_DEGRADED, lanes 1 and 3 differ -> that output has illegal_instr_o=1, fault_o=1, state_o=10.
REQ-035 SHALL test: out_ready_i=0 for 5 cycles with a held transfer -> in_ready_o=0, outputs stable, counters unchanged.
REQ-036 SHALL test: clear_i together with an acceptance while in TMR_FAIL -> next cycle state_o=00, lane_dis_o=0, mismatch_cnt_o=0, output still valid.
REQ-037 SHALL test: rst_n pulsed low with out_valid_o=1 -> out_valid_o=0 immediately, all outputs at reset values.
